// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter sharing one UART transmitter between
// NUM_REQ byte-stream requesters. A requester whose byte has req_last=0 keeps
// the grant for the rest of its burst (capped at MAX_BURST bytes). A watchdog
// releases the grant when the transmitter stalls or the held requester
// goes quiet.
module uart_tx_sched #(
    parameter int NUM_REQ     = 3,
    parameter int MAX_BURST   = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy,
    input  logic                   tx_done,
    output logic [2:0]             grant_id,
    output logic                   active,
    output logic                   timeout_err,
    output logic [15:0]            byte_cnt
);

    localparam int              BW        = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]   BURST_CAP = BW'(MAX_BURST);
    localparam logic [15:0]     TO_LAST   = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {IDLE, ACCEPT, START, WAIT_DONE, HOLD} state_t;

    state_t               state_q, state_d;
    logic [2:0]           last_grant_q, last_grant_d;
    logic [2:0]           grant_id_q, grant_id_d;
    logic                 lock_q, lock_d;
    logic [BW-1:0]        burst_cnt_q, burst_cnt_d;
    logic [15:0]          wdog_q, wdog_d;
    logic [15:0]          byte_cnt_q, byte_cnt_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic                 tx_start_q, tx_start_d;
    logic                 timeout_err_q, timeout_err_d;
    logic                 active_q, active_d;

    logic                 take;
    logic [2:0]           take_id;
    logic                 release_g;
    logic [3:0]           pick;

    // First valid requester scanning upward from last+1; returns {found, index}.
    function automatic logic [3:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                           input logic [2:0] last);
        logic [3:0] res;
        int         idx;
        res = 4'b0;
        // Walk offsets from farthest to nearest so the nearest valid one wins.
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(last) + i) % NUM_REQ;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (j == idx && valid[j]) res = {1'b1, 3'(j)};
            end
        end
        return res;
    endfunction

    function automatic logic bit_at(input logic [NUM_REQ-1:0] vec,
                                    input logic [2:0] id);
        logic b;
        b = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (j == int'(id)) b = vec[j];
        end
        return b;
    endfunction

    // Next-state and registered-output computation for the grant FSM.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_id_d    = grant_id_q;
        lock_d        = lock_q;
        burst_cnt_d   = burst_cnt_q;
        wdog_d        = wdog_q;
        byte_cnt_d    = byte_cnt_q;
        tx_data_d     = tx_data_q;
        req_ready_d   = '0;
        tx_start_d    = 1'b0;
        timeout_err_d = 1'b0;
        take          = 1'b0;
        take_id       = grant_id_q;
        release_g     = 1'b0;
        pick          = rr_pick(req_valid, last_grant_q);

        case (state_q)
            IDLE: begin
                if (!tx_busy && pick[3]) begin
                    take    = 1'b1;
                    take_id = pick[2:0];
                end
            end
            ACCEPT: begin
                // Watchdog reads 0 while tx_start is high.
                tx_start_d = 1'b1;
                wdog_d     = '0;
                state_d    = START;
            end
            START: begin
                wdog_d  = wdog_q + 16'd1;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                // Completion wins over a watchdog expiry in the same cycle.
                if (tx_done) begin
                    byte_cnt_d = byte_cnt_q + 16'd1;
                    if (lock_q && burst_cnt_q < BURST_CAP) begin
                        state_d = HOLD;
                        wdog_d  = '0;
                    end else begin
                        release_g = 1'b1;
                    end
                end else if (wdog_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    release_g     = 1'b1;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
            end
            HOLD: begin
                if (bit_at(req_valid, grant_id_q) && !tx_busy) begin
                    take    = 1'b1;
                    take_id = grant_id_q;
                end else if (wdog_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    release_g     = 1'b1;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Releasing makes this requester the lowest priority next round.
        if (release_g) begin
            state_d      = IDLE;
            burst_cnt_d  = '0;
            lock_d       = 1'b0;
            wdog_d       = '0;
            last_grant_d = grant_id_q;
        end

        // Latch the byte and pulse req_ready during the ACCEPT cycle.
        if (take) begin
            state_d     = ACCEPT;
            grant_id_d  = take_id;
            burst_cnt_d = burst_cnt_q + BW'(1);
            for (int j = 0; j < NUM_REQ; j++) begin
                if (j == int'(take_id)) begin
                    req_ready_d[j] = 1'b1;
                    tx_data_d      = req_data[8*j +: 8];
                    lock_d         = ~req_last[j];
                end
            end
        end

        active_d = (state_d != IDLE);
    end

    // State and output registers; reset gives requester 0 top priority.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q       <= IDLE;
            last_grant_q  <= 3'(NUM_REQ - 1);
            grant_id_q    <= '0;
            lock_q        <= 1'b0;
            burst_cnt_q   <= '0;
            wdog_q        <= '0;
            byte_cnt_q    <= '0;
            tx_data_q     <= '0;
            req_ready_q   <= '0;
            tx_start_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            active_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_id_q    <= grant_id_d;
            lock_q        <= lock_d;
            burst_cnt_q   <= burst_cnt_d;
            wdog_q        <= wdog_d;
            byte_cnt_q    <= byte_cnt_d;
            tx_data_q     <= tx_data_d;
            req_ready_q   <= req_ready_d;
            tx_start_q    <= tx_start_d;
            timeout_err_q <= timeout_err_d;
            active_q      <= active_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign grant_id    = grant_id_q;
    assign active      = active_q;
    assign timeout_err = timeout_err_q;
    assign byte_cnt    = byte_cnt_q;

endmodule
